// File: rtl/serial_rx_pkg.sv
// Shared types and helpers for the serial word receiver.
// Holds the FSM state encoding, the bit-order constants and the counter sizing function.
package serial_rx_pkg;

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Serial-in shift register with bit counter.
// On each shift it presents the post-shift word, and flags the shift that completes a word.
module sipo_shift_core
    import serial_rx_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic             dir,
    input  logic             bit_in,
    output logic [WIDTH-1:0] word,
    output logic             full
);

    localparam int CW = clog2(WIDTH + 1);

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] first;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt;
    logic             dir_q;

    always_comb begin
        first = '0;
        if (dir == DIR_LSB_FIRST) first[WIDTH-1] = bit_in;
        else                      first[0]       = bit_in;
        if (dir_q == DIR_LSB_FIRST) shifted = {bit_in, shreg[WIDTH-1:1]};
        else                        shifted = {shreg[WIDTH-2:0], bit_in};
    end

    // The completing bit is visible combinationally so the word can be registered on the same edge.
    assign word = shifted;
    assign full = shift && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            shreg <= '0;
            cnt   <= '0;
            dir_q <= DIR_MSB_FIRST;
        end else if (load) begin
            shreg <= first;
            cnt   <= CW'(1);
            dir_q <= dir;
        end else if (shift) begin
            shreg <= shifted;
            cnt   <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/serial_word_receiver.sv
// Framed serial-to-parallel receiver with valid/ready output register.
// Reports framing violations as a pulse and dropped words as a sticky overrun flag.
module serial_word_receiver
    import serial_rx_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sin_valid,
    input  logic             sin,
    input  logic             frame,
    input  logic             dir,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun,
    input  logic             overrun_clr
);

    state_t           state;
    logic             load;
    logic             shift;
    logic [WIDTH-1:0] word;
    logic             complete;

    assign load  = sin_valid && frame;
    assign shift = sin_valid && !frame && (state == SHIFT);

    sipo_shift_core #(.WIDTH(WIDTH)) u_core (
        .clock  (clock),
        .reset  (reset),
        .load   (load),
        .shift  (shift),
        .dir    (dir),
        .bit_in (sin),
        .word   (word),
        .full   (complete)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            dout       <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (dout_ready)  dout_valid <= 1'b0;
            if (overrun_clr) overrun    <= 1'b0;
            case (state)
                IDLE: begin
                    if (sin_valid) begin
                        if (frame) begin
                            state <= SHIFT;
                            busy  <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (sin_valid) begin
                        if (frame) begin
                            frame_err <= 1'b1;
                        end else if (complete) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            // Later assignments win: a completing word overrides the ready-clear and overrun_clr.
                            if (!dout_valid || dout_ready) begin
                                dout       <= word;
                                dout_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver (WIDTH=4).
// Accepted words are checked against a queue of expected words; flags are checked inline.
module tb_serial_word_receiver;

    logic       clock = 1'b0;
    logic       reset;
    logic       sin_valid;
    logic       sin;
    logic       frame;
    logic       dir;
    logic [3:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic       overrun_clr;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [3:0]  sb[$];

    serial_word_receiver #(.WIDTH(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .sin_valid   (sin_valid),
        .sin         (sin),
        .frame       (frame),
        .dir         (dir),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .busy        (busy),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic f, input logic b, input logic d);
        sin_valid = 1'b1;
        frame     = f;
        sin       = b;
        dir       = d;
        tick();
        sin_valid = 1'b0;
        frame     = 1'b0;
    endtask

    // Every accepted word must match the oldest expected word.
    always @(negedge clock) begin
        logic [3:0] exp;
        if (!reset && dout_valid && dout_ready) begin
            exp = (sb.size() > 0) ? sb.pop_front() : 4'bxxxx;
            check("sb_word", {28'h0, dout}, {28'h0, exp});
        end
    end

    initial begin
        reset       = 1'b1;
        sin_valid   = 1'b0;
        sin         = 1'b0;
        frame       = 1'b0;
        dir         = 1'b0;
        dout_ready  = 1'b1;
        overrun_clr = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_dout", {28'h0, dout}, 32'h0);
        check("rst_valid", {31'h0, dout_valid}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_ferr", {31'h0, frame_err}, 32'h0);
        check("rst_ovr", {31'h0, overrun}, 32'h0);

        // MSB-first 1,0,1,1 -> B, valid for exactly one cycle
        send_bit(1, 1, 0);
        check("msb_busy", {31'h0, busy}, 32'h1);
        send_bit(0, 0, 0);
        send_bit(0, 1, 0);
        sb.push_back(4'hB);
        send_bit(0, 1, 0);
        check("msb_valid", {31'h0, dout_valid}, 32'h1);
        check("msb_busy_end", {31'h0, busy}, 32'h0);
        tick();
        check("msb_valid_1cyc", {31'h0, dout_valid}, 32'h0);

        // LSB-first 1,0,1,1 -> D; dir toggled mid-word is ignored
        send_bit(1, 1, 1);
        send_bit(0, 0, 0);
        send_bit(0, 1, 1);
        sb.push_back(4'hD);
        send_bit(0, 1, 0);
        check("lsb_dout", {28'h0, dout}, 32'hD);
        tick();

        // Gapped strobes 0,1,1,0 MSB-first -> 6
        send_bit(1, 0, 0);
        repeat (3) tick();
        check("gap_busy", {31'h0, busy}, 32'h1);
        send_bit(0, 1, 0);
        repeat (3) tick();
        send_bit(0, 1, 0);
        repeat (3) tick();
        check("gap_valid_idle", {31'h0, dout_valid}, 32'h0);
        sb.push_back(4'h6);
        send_bit(0, 0, 0);
        check("gap_busy_end", {31'h0, busy}, 32'h0);
        check("gap_dout", {28'h0, dout}, 32'h6);
        tick();

        // Overrun: A held, 5 dropped
        dout_ready = 1'b0;
        send_bit(1, 1, 0); send_bit(0, 0, 0); send_bit(0, 1, 0);
        sb.push_back(4'hA);
        send_bit(0, 0, 0);
        check("ovr_validA", {31'h0, dout_valid}, 32'h1);
        send_bit(1, 0, 0); send_bit(0, 1, 0); send_bit(0, 0, 0); send_bit(0, 1, 0);
        check("ovr_flag", {31'h0, overrun}, 32'h1);
        check("ovr_dout_kept", {28'h0, dout}, 32'hA);
        check("ovr_valid_kept", {31'h0, dout_valid}, 32'h1);
        dout_ready = 1'b1;
        tick();
        check("ovr_valid_clr", {31'h0, dout_valid}, 32'h0);
        check("ovr_sticky", {31'h0, overrun}, 32'h1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("ovr_cleared", {31'h0, overrun}, 32'h0);

        // Completion coinciding with dout_ready: 9 consumed, C replaces it, no overrun
        dout_ready = 1'b0;
        send_bit(1, 1, 0); send_bit(0, 0, 0); send_bit(0, 0, 0);
        sb.push_back(4'h9);
        send_bit(0, 1, 0);
        send_bit(1, 1, 0); send_bit(0, 1, 0); send_bit(0, 0, 0);
        sb.push_back(4'hC);
        dout_ready = 1'b1;
        send_bit(0, 0, 0);
        check("same_dout", {28'h0, dout}, 32'hC);
        check("same_valid", {31'h0, dout_valid}, 32'h1);
        check("same_no_ovr", {31'h0, overrun}, 32'h0);
        tick();

        // Stray bit in IDLE
        send_bit(0, 1, 0);
        check("stray_ferr", {31'h0, frame_err}, 32'h1);
        check("stray_busy", {31'h0, busy}, 32'h0);
        check("stray_valid", {31'h0, dout_valid}, 32'h0);
        tick();
        check("stray_ferr_pulse", {31'h0, frame_err}, 32'h0);

        // Reframe after 2 bits, then 1,1,1,0 -> E
        send_bit(1, 1, 0);
        send_bit(0, 0, 0);
        send_bit(1, 1, 0);
        check("refr_ferr", {31'h0, frame_err}, 32'h1);
        check("refr_busy", {31'h0, busy}, 32'h1);
        send_bit(0, 1, 0);
        check("refr_ferr_pulse", {31'h0, frame_err}, 32'h0);
        send_bit(0, 1, 0);
        sb.push_back(4'hE);
        send_bit(0, 0, 0);
        check("refr_dout", {28'h0, dout}, 32'hE);
        tick();

        // Reset mid-word, then 0,0,1,1 -> 3
        send_bit(1, 1, 0); send_bit(0, 1, 0); send_bit(0, 1, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_dout", {28'h0, dout}, 32'h0);
        check("mrst_busy", {31'h0, busy}, 32'h0);
        check("mrst_valid", {31'h0, dout_valid}, 32'h0);
        send_bit(1, 0, 0); send_bit(0, 0, 0); send_bit(0, 1, 0);
        check("mrst_valid_early", {31'h0, dout_valid}, 32'h0);
        sb.push_back(4'h3);
        send_bit(0, 1, 0);
        check("mrst_dout_new", {28'h0, dout}, 32'h3);
        repeat (3) tick();

        check("sb_drained", sb.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
